uart_receiver: RTL and testbench

//  Serial-to-parallel 8N1 UART receiver; the stage directly downstream of the

---
 rtl/uart_receiver_if.sv | 19 +
 rtl/uart_receiver.sv | 121 ++++++++++++
 tb/tb_uart_receiver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: oversample tick and serial line in, byte and status strobes out.
interface uart_receiver_if;
   logic       clock_enable;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_error;
   logic       busy;

   modport master (
      output clock_enable, rx,
      input  data, valid, frame_error, busy
   );

   modport slave (
      input  clock_enable, rx,
      output data, valid, frame_error, busy
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver oversampling rx on clock_enable ticks; one-cycle valid / frame_error strobes.
module uart_receiver #(
   parameter int OVERSAMPLE = 16
) (
   input  logic           CLKIN,
   input  logic           RESETN,
   uart_receiver_if.slave bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state_reg, state_next;
   logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
   logic [2:0]    bit_cnt_reg, bit_cnt_next;
   logic [7:0]    shift_reg, shift_next;
   logic [7:0]    data_reg, data_next;
   logic          valid_reg, valid_next;
   logic          frame_error_reg, frame_error_next;
   logic          rx_meta_reg, rx_s_reg;

   always_ff @(posedge CLKIN) begin
      if (!RESETN) begin
         rx_meta_reg     <= 1'b1;
         rx_s_reg        <= 1'b1;
         state_reg       <= IDLE;
         tick_cnt_reg    <= '0;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         data_reg        <= '0;
         valid_reg       <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         rx_meta_reg     <= bus.rx;
         rx_s_reg        <= rx_meta_reg;
         state_reg       <= state_next;
         tick_cnt_reg    <= tick_cnt_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         data_reg        <= data_next;
         valid_reg       <= valid_next;
         frame_error_reg <= frame_error_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      tick_cnt_next    = tick_cnt_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      data_next        = data_reg;
      // Strobes default low so they drop after one cycle even without a tick
      valid_next       = 1'b0;
      frame_error_next = 1'b0;

      if (bus.clock_enable) begin
         case (state_reg)
            IDLE: begin
               if (!rx_s_reg) begin
                  state_next    = START;
                  tick_cnt_next = '0;
               end
            end
            START: begin
               if (tick_cnt_reg == TICK_MID) begin
                  tick_cnt_next = '0;
                  bit_cnt_next  = '0;
                  state_next    = rx_s_reg ? IDLE : DATA;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt_reg == TICK_LAST) begin
                  tick_cnt_next = '0;
                  shift_next    = {rx_s_reg, shift_reg[7:1]};
                  if (bit_cnt_reg == 3'd7) state_next   = STOP;
                  else                     bit_cnt_next = bit_cnt_reg + 1'b1;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
            STOP: begin
               // Leave at stop-bit centre so a start bit may follow with no gap
               if (tick_cnt_reg == TICK_LAST) begin
                  tick_cnt_next = '0;
                  if (rx_s_reg) begin
                     data_next  = shift_reg;
                     valid_next = 1'b1;
                     state_next = IDLE;
                  end else begin
                     frame_error_next = 1'b1;
                     state_next       = BREAK;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
            BREAK: begin
               if (rx_s_reg) begin
                  state_next    = IDLE;
                  tick_cnt_next = '0;
               end
            end
            default: begin
               state_next    = IDLE;
               tick_cnt_next = '0;
            end
         endcase
      end
   end

   assign bus.data        = data_reg;
   assign bus.valid       = valid_reg;
   assign bus.frame_error = frame_error_reg;
   assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames, back-to-back, glitch, break, slow tick, freeze, reset.
module tb_uart_receiver;

   logic CLKIN = 1'b0;
   logic RESETN;

   uart_receiver_if bus ();

   uart_receiver #(.OVERSAMPLE(16)) dut (
      .CLKIN  (CLKIN),
      .RESETN (RESETN),
      .bus    (bus.slave)
   );

   always #5 CLKIN = ~CLKIN;

   int passed = 0;
   int total  = 0;

   // Monitor state, sampled on the falling edge
   int         cyc = 0;
   int         valid_cnt = 0;
   int         fe_cnt = 0;
   int         busy_cnt = 0;
   int         both_cnt = 0;
   int         wide_cnt = 0;
   int         valid_time = 0;
   int         valid_time_prev = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;
   logic       valid_prev = 1'b0;
   logic       fe_prev = 1'b0;

   // Tick generator settings
   int   ce_period = 1;
   int   ce_cnt = 0;
   logic ce_en = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else begin
         passed++;
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge CLKIN);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb);
      bus.rx = 1'b0;
      wait_clks(cpb);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         wait_clks(cpb);
      end
      bus.rx = stop;
      wait_clks(cpb);
   endtask

   always @(negedge CLKIN) begin
      cyc++;
      if (bus.valid) begin
         valid_cnt++;
         prev_data       = last_data;
         last_data       = bus.data;
         valid_time_prev = valid_time;
         valid_time      = cyc;
         if (valid_prev) wide_cnt++;
      end
      if (bus.frame_error) begin
         fe_cnt++;
         if (fe_prev) wide_cnt++;
      end
      if (bus.valid && bus.frame_error) both_cnt++;
      if (bus.busy) busy_cnt++;
      valid_prev = bus.valid;
      fe_prev    = bus.frame_error;
   end

   initial begin
      bus.clock_enable = 1'b0;
      forever begin
         @(posedge CLKIN);
         #1;
         if (ce_cnt + 1 >= ce_period) ce_cnt = 0;
         else                         ce_cnt++;
         bus.clock_enable = ce_en && (ce_cnt == 0);
      end
   end

   initial begin
      int v0, f0, b0;
      RESETN = 1'b0;
      bus.rx = 1'b1;
      wait_clks(3);
      RESETN = 1'b1;
      wait_clks(1);
      check("reset_data", bus.data, 8'h00);
      check("reset_valid", bus.valid, 1'b0);
      check("reset_fe", bus.frame_error, 1'b0);
      check("reset_busy", bus.busy, 1'b0);

      // Single frame 0xA5
      v0 = valid_cnt; f0 = fe_cnt;
      send_frame(8'hA5, 1'b1, 16);
      bus.rx = 1'b1;
      wait_clks(20);
      check("a5_valid_cnt", valid_cnt - v0, 1);
      check("a5_strobe_data", last_data, 8'hA5);
      check("a5_data_held", bus.data, 8'hA5);
      check("a5_fe_cnt", fe_cnt - f0, 0);
      check("a5_busy", bus.busy, 1'b0);

      // Back-to-back 0x00 then 0xFF
      v0 = valid_cnt;
      send_frame(8'h00, 1'b1, 16);
      send_frame(8'hFF, 1'b1, 16);
      bus.rx = 1'b1;
      wait_clks(20);
      check("b2b_valid_cnt", valid_cnt - v0, 2);
      check("b2b_first", prev_data, 8'h00);
      check("b2b_second", last_data, 8'hFF);
      check("b2b_gap", valid_time - valid_time_prev, 160);

      // Short low glitch
      v0 = valid_cnt; f0 = fe_cnt; b0 = busy_cnt;
      bus.rx = 1'b0;
      wait_clks(4);
      bus.rx = 1'b1;
      wait_clks(30);
      check("glitch_busy_seen", (busy_cnt - b0) > 0, 1'b1);
      check("glitch_busy_end", bus.busy, 1'b0);
      check("glitch_valid", valid_cnt - v0, 0);
      check("glitch_fe", fe_cnt - f0, 0);
      check("glitch_data", bus.data, 8'hFF);

      // Bad stop bit followed by a held-low line
      v0 = valid_cnt; f0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 16);
      wait_clks(40);
      check("brk_fe_cnt", fe_cnt - f0, 1);
      check("brk_valid", valid_cnt - v0, 0);
      check("brk_data", bus.data, 8'hFF);
      check("brk_busy_low_line", bus.busy, 1'b1);
      bus.rx = 1'b1;
      wait_clks(6);
      check("brk_busy_released", bus.busy, 1'b0);
      send_frame(8'h3C, 1'b1, 16);
      bus.rx = 1'b1;
      wait_clks(20);
      check("brk_next_valid", valid_cnt - v0, 1);
      check("brk_next_data", bus.data, 8'h3C);
      check("brk_fe_once", fe_cnt - f0, 1);

      // Tick every 4th clock, 64 clocks per bit
      ce_period = 4;
      v0 = valid_cnt;
      send_frame(8'h81, 1'b1, 64);
      bus.rx = 1'b1;
      wait_clks(80);
      check("slow_valid", valid_cnt - v0, 1);
      check("slow_data", bus.data, 8'h81);
      ce_period = 1;
      wait_clks(4);

      // Freeze with clock_enable held low in START
      v0 = valid_cnt;
      bus.rx = 1'b0;
      wait_clks(6);
      ce_en = 1'b0;
      bus.rx = 1'b1;
      wait_clks(50);
      check("freeze_busy", bus.busy, 1'b1);
      ce_en = 1'b1;
      wait_clks(30);
      check("freeze_resume_idle", bus.busy, 1'b0);
      check("freeze_no_valid", valid_cnt - v0, 0);

      // Reset during bit 4 of a 0x5A frame
      v0 = valid_cnt; f0 = fe_cnt;
      bus.rx = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 4; i++) begin
         bus.rx = 8'h5A >> i;
         wait_clks(16);
      end
      bus.rx = 1'b1;
      wait_clks(8);
      check("rst_mid_busy_before", bus.busy, 1'b1);
      RESETN = 1'b0;
      wait_clks(1);
      RESETN = 1'b1;
      check("rst_mid_data", bus.data, 8'h00);
      check("rst_mid_busy", bus.busy, 1'b0);
      check("rst_mid_valid", bus.valid, 1'b0);
      check("rst_mid_fe", bus.frame_error, 1'b0);
      wait_clks(200);
      check("rst_mid_no_strobe", (valid_cnt - v0) + (fe_cnt - f0), 0);
      send_frame(8'h5A, 1'b1, 16);
      bus.rx = 1'b1;
      wait_clks(20);
      check("rst_after_valid", valid_cnt - v0, 1);
      check("rst_after_data", bus.data, 8'h5A);

      check("strobes_exclusive", both_cnt, 0);
      check("strobes_single_cycle", wide_cnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
